code_lock_decoder: RTL and testbench

Parametrised, registered code decoder with input qualification. It samples an `IN_W`-bit input code on every clock and accepts the code only after it has been stable for `HOLD` consecutive edges. An accepted code is then translated through a run-time programmable lookup table into an `OUT_W`-bit output. Codes with no table entry drive a defined default value and are counted; the block never outputs X. It sits between raw control inputs and downstream logic that needs glitch-free, fully defined decode results.

---
 rtl/code_lock_pkg.sv | 17 +
 rtl/code_table.sv | 42 ++++
 rtl/code_lock_decoder.sv | 104 ++++++++++
 tb/tb_code_lock_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared definitions for the code lock decoder: FSM state type and the
// default parameter values used by the top level and its table.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_LOCK = 2'd2
    } lock_state_t;

    localparam int DEF_IN_W    = 3;
    localparam int DEF_OUT_W   = 2;
    localparam int DEF_HOLD    = 2;
    localparam int DEF_DEFAULT = 0;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/code_table.sv
// Run-time programmable lookup table: 2^IN_W entries of {valid, data},
// one synchronous write port and one combinational read port. A read of
// the address being written in the same cycle returns the old contents.
module code_table
    import code_lock_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IN_W-1:0]  waddr,
    input  logic [OUT_W-1:0] wdata,
    input  logic             wvalid,
    input  logic [IN_W-1:0]  raddr,
    output logic [OUT_W-1:0] rdata,
    output logic             rvalid
);

    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    // Entry storage; reset clears data as well so reads are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (we) begin
            vld_q[waddr]  <= wvalid;
            data_q[waddr] <= wdata;
        end
    end

    assign rdata  = data_q[raddr];
    assign rvalid = vld_q[raddr];

endmodule

// File: rtl/code_lock_decoder.sv
// Registered code decoder with input qualification: a code must be sampled
// HOLD consecutive times before it is accepted and translated through the
// programmable table. Unmapped codes drive DEFAULT and bump a saturating
// miss counter.
module code_lock_decoder
    import code_lock_pkg::*;
#(
    parameter int             IN_W    = DEF_IN_W,
    parameter int             OUT_W   = DEF_OUT_W,
    parameter int             HOLD    = DEF_HOLD,
    parameter logic [OUT_W-1:0] DEFAULT = OUT_W'(DEF_DEFAULT),
    parameter int             CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_code,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic [OUT_W-1:0] y,
    output logic             hit,
    output logic             miss,
    output logic             upd,
    output logic             locked,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int CW = $clog2(HOLD + 1);

    lock_state_t      state;
    logic [IN_W-1:0]  cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             same;
    logic             reload;
    logic             accept;
    logic [OUT_W-1:0] tbl_data;
    logic             tbl_vld;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    code_table #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wdata  (cfg_data),
        .wvalid (cfg_valid),
        .raddr  (in_code),
        .rdata  (tbl_data),
        .rvalid (tbl_vld)
    );

    // Qualification decision: restart the count on a new code, otherwise
    // extend it; accept on the edge where the count lands exactly on HOLD.
    always_comb begin
        same    = (in_code == cand);
        reload  = (state != ST_LOCK) || !same;
        cnt_nxt = ((state == ST_IDLE) || !same) ? CW'(1) : cnt + CW'(1);
        accept  = reload && (cnt_nxt == CW'(HOLD));
    end

    // FSM, candidate tracking and registered decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= '0;
            cnt      <= '0;
            y        <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            upd      <= 1'b0;
            locked   <= 1'b0;
            miss_cnt <= '0;
        end else begin
            upd <= accept;
            if (reload) begin
                cand   <= in_code;
                cnt    <= cnt_nxt;
                state  <= accept ? ST_LOCK : ST_QUAL;
                locked <= accept;
            end
            if (accept) begin
                if (tbl_vld) begin
                    y    <= tbl_data;
                    hit  <= 1'b1;
                    miss <= 1'b0;
                end else begin
                    y        <= DEFAULT;
                    hit      <= 1'b0;
                    miss     <= 1'b1;
                    miss_cnt <= sat_inc(miss_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_code_lock_decoder.sv
// Bench for code_lock_decoder: directed scenarios followed by random
// traffic, all checked against a run-length based reference model.
module tb_code_lock_decoder;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_code;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_data;
    logic       cfg_valid;

    logic [1:0] y, y2;
    logic       hit, miss, upd, locked;
    logic       hit2, miss2, upd2, locked2;
    logic [7:0] miss_cnt;
    logic [1:0] miss_cnt2;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [1:0] m_data [8];
    bit         m_vld  [8];
    int         run_len;
    logic [2:0] last_s;
    logic [1:0] m_y;
    bit         m_hit, m_miss, m_upd;
    int         m_misses;

    always #5 clk = ~clk;

    code_lock_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .y(y), .hit(hit), .miss(miss), .upd(upd), .locked(locked), .miss_cnt(miss_cnt)
    );

    code_lock_decoder #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .y(y2), .hit(hit2), .miss(miss2), .upd(upd2), .locked(locked2), .miss_cnt(miss_cnt2)
    );

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = 2'b00;
            m_vld[i]  = 1'b0;
        end
        run_len  = 0;
        last_s   = 3'b000;
        m_y      = 2'b00;
        m_hit    = 1'b0;
        m_miss   = 1'b0;
        m_upd    = 1'b0;
        m_misses = 0;
    endtask

    // A code is accepted on the edge where its run of identical samples
    // reaches exactly HOLD; lookup sees the table before this edge's write.
    task automatic model_edge();
        if (run_len == 0 || in_code != last_s) run_len = 1;
        else if (run_len <= HOLD) run_len = run_len + 1;
        last_s = in_code;
        m_upd  = (run_len == HOLD);
        if (m_upd) begin
            if (m_vld[in_code]) begin
                m_y = m_data[in_code]; m_hit = 1'b1; m_miss = 1'b0;
            end else begin
                m_y = 2'b00; m_hit = 1'b0; m_miss = 1'b1;
                m_misses = m_misses + 1;
            end
        end
        if (cfg_we) begin
            m_vld[cfg_addr]  = cfg_valid;
            m_data[cfg_addr] = cfg_data;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sat8, sat2;
        sat8 = (m_misses > 255) ? 255 : m_misses;
        sat2 = (m_misses > 3) ? 3 : m_misses;
        chk({tag, ".y"},       32'(y),         32'(m_y));
        chk({tag, ".hit"},     32'(hit),       32'(m_hit));
        chk({tag, ".miss"},    32'(miss),      32'(m_miss));
        chk({tag, ".upd"},     32'(upd),       32'(m_upd));
        chk({tag, ".locked"},  32'(locked),    32'(run_len >= HOLD));
        chk({tag, ".cnt8"},    32'(miss_cnt),  32'(sat8));
        chk({tag, ".cnt2"},    32'(miss_cnt2), 32'(sat2));
        chk({tag, ".y_c2"},    32'(y2),        32'(m_y));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_all(tag);
        cfg_we = 1'b0;
    endtask

    // Called at posedge+1: pulse reset between edges and check immediately.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        chk({tag, ".y0"},      32'(y),        32'(0));
        chk({tag, ".locked0"}, 32'(locked),   32'(0));
        chk({tag, ".cnt0"},    32'(miss_cnt), 32'(0));
        #2 rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] d, input logic v);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_valid = v;
    endtask

    initial begin
        int exp_sat [5] = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; in_code = 3'b111;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
        model_reset();

        // reset held across edges, then release with 111 held
        step("rst0");
        step("rst1");
        #2 rst_n = 1'b1;
        step("idle");
        chk("first.locked", 32'(locked), 32'(0));
        step("acc111");
        chk("first.miss", 32'(miss), 32'(1));
        chk("first.upd",  32'(upd),  32'(1));
        chk("first.cnt",  32'(miss_cnt), 32'(1));
        step("post111");
        chk("first.updlo", 32'(upd), 32'(0));

        // program table while parked on 000
        in_code = 3'b000;
        wr(3'b111, 2'b01, 1'b1); step("prog0");
        wr(3'b110, 2'b11, 1'b1); step("prog1");
        wr(3'b100, 2'b00, 1'b1); step("prog2");
        in_code = 3'b111;
        step("q111");
        step("acc111b");
        chk("hit111.y",      32'(y),      32'(1));
        chk("hit111.hit",    32'(hit),    32'(1));
        chk("hit111.locked", 32'(locked), 32'(1));
        step("hold111");

        // one-cycle glitch to 110
        in_code = 3'b110;
        step("glitch");
        chk("glitch.y",      32'(y),      32'(1));
        chk("glitch.locked", 32'(locked), 32'(0));
        in_code = 3'b111;
        step("ret1");
        chk("ret1.upd", 32'(upd), 32'(0));
        step("ret2");
        chk("ret2.upd", 32'(upd), 32'(1));
        chk("ret2.y",   32'(y),   32'(1));

        // write/lookup collision on 011
        in_code = 3'b011;
        step("q011");
        wr(3'b011, 2'b10, 1'b1);
        step("col011");
        chk("col.miss", 32'(miss), 32'(1));
        chk("col.y",    32'(y),    32'(0));
        in_code = 3'b000;
        step("leave0"); step("leave1");
        in_code = 3'b011;
        step("back0"); step("back1");
        chk("back.hit", 32'(hit), 32'(1));
        chk("back.y",   32'(y),   32'(2));

        // miss counter saturation on the narrow instance
        async_reset("rst_sat");
        for (int k = 0; k < 5; k++) begin
            in_code = (k % 2 == 0) ? 3'b000 : 3'b001;
            step("sat_q");
            step("sat_a");
            chk("sat.cnt2", 32'(miss_cnt2), 32'(exp_sat[k]));
            chk("sat.cnt8", 32'(miss_cnt),  32'(k + 1));
        end

        // reset mid-qualification drops programmed entries
        in_code = 3'b111;
        wr(3'b111, 2'b01, 1'b1);
        step("mq0"); step("mq1");
        chk("mq.hit", 32'(hit), 32'(1));
        in_code = 3'b000;
        step("mq_qual");
        async_reset("rst_mq");
        in_code = 3'b111;
        step("mq2"); step("mq3");
        chk("mq.miss", 32'(miss), 32'(1));
        chk("mq.hit0", 32'(hit),  32'(0));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) in_code = 3'($urandom);
            if ($urandom_range(0, 5) == 0)
                wr(3'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
            step("rnd");
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
